ni_flit_tx: RTL and testbench
=============================

Name: ni_flit_tx

Overview:
- Source-side network interface: the transmitter that drives a router's resource input channel (resource_in_f / resource_in_b).
- Accepts a packet descriptor and body words from the local core.
- Builds 35-bit flits and sends them one at a time using a four-phase req/ack handshake.
- Sits between the core and the router; tb ties it to router resource_in_f/resource_in_b.

Parameters:
- SRC_ID, 5'd0, source node id placed in header bits [31:27].
- SYNC_STAGES, 2, flops in the ack synchronizer (allowed range 2..3).
- MAX_LEN, 15, maximum body words per packet; pkt_len above this is clamped.

Ports:
- clk  input  1  clock.
- preset  input  1  synchronous active-high reset.
- pkt_valid  input  1  core offers a packet descriptor.
- pkt_ready  output  1  descriptor accepted when pkt_valid & pkt_ready.
- pkt_dest  input  6  destination address, goes to header [5:0].
- pkt_len  input  4  number of body words, 0..15.
- word_valid  input  1  core offers a body word.
- word_ready  output  1  word accepted when word_valid & word_ready.
- word_data  input  32  body payload.
- out_f  output  channel_forward (req 1, data 35)  forward channel to router.
- out_b  input  channel_backward (ack 1)  backward channel from router.
- busy  output  1  packet in flight.
- proto_err  output  1  sticky: synchronized ack high while req low in IDLE.
- flit_cnt  output  16  total flits completed, wraps at 2^16.

Behaviour:
- Clock and reset: one clock clk; reset preset is synchronous and active-high.
- Reset values (on preset=1 at a clk edge): out_f.req=0, out_f.data=0, pkt_ready=0, word_ready=0, busy=0, proto_err=0, flit_cnt=0, synchronizer cleared, FSM=IDLE.
- Reset asserted mid-packet aborts the packet: req drops on the next edge and no further flits are sent.
- Flit formats:
  - Header: [34:32] type; [31:27] SRC_ID; [26:22] {1'b0, len}; [21:6] 0; [5:0] dest.
  - Body: [34:32] type; [31:0] word.
- Type codes: 3'b110 single (header with len=0), 3'b100 head, 3'b001 body, 3'b011 tail (last body word).
- ack_s is out_b.ack delayed through SYNC_STAGES flops. All handshake decisions use ack_s.
- FSM states:
  - IDLE: pkt_ready=1. On descriptor accept, latch dest and len (clamped to MAX_LEN), set busy=1, build the header into out_f.data, go to SETUP.
  - SETUP: data stays stable for one cycle; req=0. Next state REQ_HI.
  - REQ_HI: req=1. Wait for ack_s=1, then req=0 and go to ACK_LO.
  - ACK_LO: req=0, data held. Wait for ack_s=0, then increment flit_cnt. If remaining body count is 0, go to IDLE and clear busy. Otherwise go to FETCH.
  - FETCH: word_ready=1. On word accept, load the body flit (type 001, or 011 if it is the last word), decrement the remaining count, go to SETUP. Stall indefinitely while word_valid=0.
- Data rule: out_f.data changes only in IDLE->SETUP and FETCH->SETUP, never while req=1 or while ack_s=1.
- req never rises while ack_s=1.
- Minimum flit period is 4 + 2*SYNC_STAGES cycles with an immediate ack.
- len=0 sends exactly one flit of type 110, and word_ready never asserts.
- pkt_ready=0 outside IDLE, so back-to-back descriptors are serialized.
- proto_err: set in IDLE when ack_s=1. Cleared only by preset.
- Unbounded wait on ack: no timeout.

Test Plan:
- Reset: hold preset=1 for 3 cycles with pkt_valid=1 -> req=0, data=0, pkt_ready=0, flit_cnt=0. Release -> pkt_ready=1 one cycle later.
- Single flit: SRC_ID=0, dest=6'b001011, len=0; responder acks 3 cycles after req -> data=35'h6_0000_000B (110_00000_00000_0…_001011) stable while req=1; req falls after ack_s=1; flit_cnt=1; busy=0 after ack low.
- Three-word packet: dest=2, len=3, words A5A5A5A5, 0000FFFF, 12345678 -> four flits with types 100/001/001/011. Header [26:22]=00011. flit_cnt=4. No data change while req=1.
- Word stall: len=2, word_valid low for 10 cycles after the header -> FSM stays in FETCH, req=0; resumes correctly when word_valid rises.
- Reset mid-packet: assert preset while req=1 on the 2nd flit -> req=0 next edge, busy=0, flit_cnt=0; a new packet afterwards sends normally.
- Protocol error: drive ack=1 while IDLE -> proto_err=1 after SYNC_STAGES+1 cycles; it remains 1 until preset.

Source files
------------

// File: rtl/ni_flit_tx.sv
// ni_flit_tx - source-side network interface transmitter.
//
// Takes a packet descriptor (dest, len) and len body words from the local core.
// Emits one header flit and then one flit per body word on a four-phase req/ack
// channel toward a router resource input.
//
// Ports
//   clk         clock
//   preset      synchronous active-high reset
//   pkt_valid   core offers a descriptor;  pkt_ready  descriptor accepted (IDLE only)
//   pkt_dest    destination address (header [5:0])
//   pkt_len     body word count, clamped to MAX_LEN
//   word_valid  core offers a body word;   word_ready word accepted (FETCH only)
//   word_data   body payload
//   out_f       forward channel {req, data[34:0]}
//   out_b       backward channel {ack}, asynchronous to clk
//   busy        packet in flight
//   proto_err   sticky: synchronized ack seen high while idle
//   flit_cnt    completed flits, wraps at 2^16
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a descriptor, pkt_ready high
// S_SETUP  | flit data launched, req low for one cycle of data setup
// S_REQ_HI | req high, waiting for synchronized ack high
// S_ACK_LO | req low, waiting for synchronized ack low (flit complete)
// S_FETCH  | word_ready high, waiting for the next body word

package ni_flit_pkg;
  typedef struct packed {
    logic        req;
    logic [34:0] data;
  } channel_forward;

  typedef struct packed {
    logic ack;
  } channel_backward;
endpackage

module ni_flit_tx
  import ni_flit_pkg::*;
#(
  parameter logic [4:0] SRC_ID      = 5'd0,
  parameter int         SYNC_STAGES = 2,
  parameter int         MAX_LEN     = 15
) (
  input  logic            clk,
  input  logic            preset,
  input  logic            pkt_valid,
  output logic            pkt_ready,
  input  logic [5:0]      pkt_dest,
  input  logic [3:0]      pkt_len,
  input  logic            word_valid,
  output logic            word_ready,
  input  logic [31:0]     word_data,
  output channel_forward  out_f,
  input  channel_backward out_b,
  output logic            busy,
  output logic            proto_err,
  output logic [15:0]     flit_cnt
);

  localparam logic [2:0] TYPE_SINGLE = 3'b110;
  localparam logic [2:0] TYPE_HEAD   = 3'b100;
  localparam logic [2:0] TYPE_BODY   = 3'b001;
  localparam logic [2:0] TYPE_TAIL   = 3'b011;
  localparam logic [3:0] LP_MAX_LEN  = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ_HI,
    S_ACK_LO,
    S_FETCH
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_ack_s;
  logic                   r_en;
  logic [34:0]            r_data;
  logic [3:0]             r_rem;
  logic                   r_proto_err;
  logic [15:0]            r_flit_cnt;
  logic                   w_req;
  logic                   w_pkt_acc;
  logic                   w_word_acc;
  logic                   w_flit_done;
  logic [3:0]             w_len;

  assign w_ack_s = r_sync[SYNC_STAGES-1];
  assign w_len   = (pkt_len > LP_MAX_LEN) ? LP_MAX_LEN : pkt_len;

  // r_en holds pkt_ready low through reset and for the first cycle after it.
  always_ff @(posedge clk) begin
    if (preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    pkt_ready  = 1'b0;
    word_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        pkt_ready = r_en;
        if (pkt_valid && r_en) w_next = S_SETUP;
      end
      // Holding here while ack is still high keeps req from rising against a
      // stale ack (only reachable after a protocol error in IDLE).
      S_SETUP: begin
        if (!w_ack_s) w_next = S_REQ_HI;
      end
      S_REQ_HI: begin
        w_req = 1'b1;
        if (w_ack_s) w_next = S_ACK_LO;
      end
      S_ACK_LO: begin
        if (!w_ack_s) w_next = (r_rem == 4'd0) ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        word_ready = 1'b1;
        if (word_valid) w_next = S_SETUP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_pkt_acc   = (r_state == S_IDLE) && pkt_valid && pkt_ready;
  assign w_word_acc  = (r_state == S_FETCH) && word_valid;
  assign w_flit_done = (r_state == S_ACK_LO) && !w_ack_s;

  always_ff @(posedge clk) begin
    if (preset) begin
      r_sync      <= '0;
      r_en        <= 1'b0;
      r_data      <= '0;
      r_rem       <= 4'd0;
      r_proto_err <= 1'b0;
      r_flit_cnt  <= 16'd0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], out_b.ack};
      r_en   <= 1'b1;
      if (w_pkt_acc) begin
        r_rem  <= w_len;
        r_data <= {(w_len == 4'd0) ? TYPE_SINGLE : TYPE_HEAD,
                   SRC_ID, 1'b0, w_len, 16'h0000, pkt_dest};
      end else if (w_word_acc) begin
        r_rem  <= r_rem - 4'd1;
        r_data <= {(r_rem == 4'd1) ? TYPE_TAIL : TYPE_BODY, word_data};
      end
      if (w_flit_done) r_flit_cnt <= r_flit_cnt + 16'd1;
      if ((r_state == S_IDLE) && w_ack_s) r_proto_err <= 1'b1;
    end
  end

  assign out_f     = {w_req, r_data};
  assign busy      = (r_state != S_IDLE);
  assign proto_err = r_proto_err;
  assign flit_cnt  = r_flit_cnt;

endmodule

// File: tb/tb_ni_flit_tx.sv
module tb_ni_flit_tx;
  import ni_flit_pkg::*;

  localparam logic [4:0] SRC = 5'd0;

  logic            clk = 1'b0;
  logic            preset;
  logic            pkt_valid;
  logic            pkt_ready;
  logic [5:0]      pkt_dest;
  logic [3:0]      pkt_len;
  logic            word_valid;
  logic            word_ready;
  logic [31:0]     word_data;
  channel_forward  out_f;
  channel_backward out_b;
  logic            busy;
  logic            proto_err;
  logic [15:0]     flit_cnt;

  logic        ack_drv   = 1'b0;
  logic        force_ack = 1'b0;
  int          n_tests   = 0;
  int          n_fail    = 0;
  logic [34:0] exp_q[$];
  int          exp_cnt   = 0;
  int          ack_dly   = 3;
  bit          rand_ack  = 1'b0;
  int          req_rises = 0;
  logic [34:0] last_flit = '0;
  logic [31:0] words[16];

  ni_flit_tx #(
    .SRC_ID      (SRC),
    .SYNC_STAGES (2),
    .MAX_LEN     (15)
  ) dut (
    .clk        (clk),
    .preset     (preset),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dest   (pkt_dest),
    .pkt_len    (pkt_len),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .out_f      (out_f),
    .out_b      (out_b),
    .busy       (busy),
    .proto_err  (proto_err),
    .flit_cnt   (flit_cnt)
  );

  always #5 clk = ~clk;

  always_comb out_b.ack = ack_drv | force_ack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference flit builders: field values placed by arithmetic from the flit format.
  function automatic logic [34:0] hdr_flit(input logic [5:0] d, input int l);
    int          lc;
    logic [34:0] f;
    lc = (l > 15) ? 15 : l;
    f  = (lc == 0) ? (35'd6 << 32) : (35'd4 << 32);
    f  = f + (35'(SRC) << 27) + (35'(lc) << 22) + 35'(d);
    return f;
  endfunction

  function automatic logic [34:0] body_flit(input logic [31:0] w, input bit last);
    return (last ? (35'd3 << 32) : (35'd1 << 32)) + 35'(w);
  endfunction

  function automatic int pick_dly();
    return rand_ack ? int'($urandom_range(0, 4)) : ack_dly;
  endfunction

  // Four-phase responder standing in for the router resource input.
  initial begin : responder
    bit          inflight;
    int          cnt;
    bit          bad;
    logic [34:0] cap;
    inflight = 1'b0;
    cnt      = 0;
    bad      = 1'b0;
    cap      = '0;
    forever begin
      @(negedge clk);
      if (preset) begin
        ack_drv  = 1'b0;
        inflight = 1'b0;
        cnt      = 0;
        bad      = 1'b0;
      end else begin
        if (out_f.req && !inflight) begin
          inflight  = 1'b1;
          cap       = out_f.data;
          bad       = 1'b0;
          cnt       = pick_dly();
          req_rises++;
          last_flit = cap;
          check("req_rise_with_ack_low", ack_drv, 0);
          check("flit_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("flit_data", cap, exp_q.pop_front());
        end else if (inflight && (out_f.data !== cap)) begin
          bad = 1'b1;
        end
        if (inflight) begin
          if (!ack_drv && out_f.req) begin
            if (cnt == 0) begin
              ack_drv = 1'b1;
              cnt     = pick_dly();
            end else cnt--;
          end else if (ack_drv && !out_f.req) begin
            if (cnt == 0) begin
              ack_drv  = 1'b0;
              inflight = 1'b0;
              check("data_stable", bad, 0);
            end else cnt--;
          end
        end
      end
    end
  end

  task automatic drive_desc(input logic [5:0] d, input logic [3:0] l);
    int ok;
    ok = 0;
    @(posedge clk); #1;
    pkt_valid = 1'b1;
    pkt_dest  = d;
    pkt_len   = l;
    for (int c = 0; c < 1000 && ok == 0; c++) begin
      @(negedge clk);
      if (pkt_ready) ok = 1;
    end
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    pkt_dest  = 6'($urandom);
    pkt_len   = 4'($urandom);
    check("desc_accepted", ok, 1);
  endtask

  task automatic drive_word(input logic [31:0] w, input int stall);
    int ok;
    ok = 0;
    @(posedge clk); #1;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    word_valid = 1'b1;
    word_data  = w;
    for (int c = 0; c < 1000 && ok == 0; c++) begin
      @(negedge clk);
      if (word_ready) ok = 1;
    end
    @(posedge clk); #1;
    word_valid = 1'b0;
    word_data  = $urandom;
    check("word_accepted", ok, 1);
  endtask

  task automatic send_pkt(input logic [5:0] d, input int l, input int max_stall,
                          input int first_stall);
    int ok;
    bit wr_seen;
    wr_seen = 1'b0;
    exp_q.push_back(hdr_flit(d, l));
    for (int i = 0; i < l; i++) exp_q.push_back(body_flit(words[i], i == l - 1));
    exp_cnt = (exp_cnt + l + 1) % 65536;
    drive_desc(d, l[3:0]);
    if (l > 0 && first_stall > 0) begin
      ok = 0;
      for (int c = 0; c < 1000 && ok == 0; c++) begin
        @(negedge clk);
        if (word_ready) ok = 1;
      end
      check("fetch_reached", ok, 1);
      repeat (first_stall) @(negedge clk);
      check("stall_req_low", out_f.req, 0);
      check("stall_word_ready", word_ready, 1);
      check("stall_busy", busy, 1);
    end
    for (int i = 0; i < l; i++)
      drive_word(words[i], (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0);
    ok = 0;
    for (int c = 0; c < 2000 && ok == 0; c++) begin
      @(negedge clk);
      if (word_ready) wr_seen = 1'b1;
      if (!busy) ok = 1;
    end
    check("pkt_done", ok, 1);
    check("flit_cnt", flit_cnt, exp_cnt);
    check("all_flits_sent", exp_q.size(), 0);
    if (l == 0) check("len0_no_word_ready", wr_seen, 0);
  endtask

  initial begin : main
    int ok;
    int l;
    int rises;
    preset     = 1'b1;
    pkt_valid  = 1'b1;
    pkt_dest   = 6'h3F;
    pkt_len    = 4'd5;
    word_valid = 1'b0;
    word_data  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", out_f.req, 0);
    check("rst_data", out_f.data, 0);
    check("rst_pkt_ready", pkt_ready, 0);
    check("rst_flit_cnt", flit_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_word_ready", word_ready, 0);
    @(posedge clk); #1;
    preset    = 1'b0;
    pkt_valid = 1'b0;
    @(negedge clk);
    check("ready_before_release_edge", pkt_ready, 0);
    @(negedge clk);
    check("ready_after_release", pkt_ready, 1);

    send_pkt(6'b001011, 0, 0, 0);
    check("single_flit_value", last_flit, 35'h6_0000_000B);
    check("single_busy_low", busy, 0);

    words[0] = 32'hA5A5A5A5;
    words[1] = 32'h0000FFFF;
    words[2] = 32'h12345678;
    send_pkt(6'd2, 3, 0, 0);
    check("tail_flit_value", last_flit, 35'h3_1234_5678);

    words[0] = 32'hDEADBEEF;
    words[1] = 32'hCAFEF00D;
    send_pkt(6'd17, 2, 0, 10);

    words[0] = 32'h11112222;
    words[1] = 32'h33334444;
    words[2] = 32'h55556666;
    exp_q.push_back(hdr_flit(6'd9, 3));
    for (int i = 0; i < 3; i++) exp_q.push_back(body_flit(words[i], i == 2));
    drive_desc(6'd9, 4'd3);
    drive_word(words[0], 0);
    ok = 0;
    for (int c = 0; c < 200 && ok == 0; c++) begin
      @(negedge clk);
      if (out_f.req) ok = 1;
    end
    check("midrst_second_req", ok, 1);
    check("midrst_second_is_body", out_f.data, body_flit(words[0], 1'b0));
    rises = req_rises;
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    @(negedge clk);
    check("midrst_req", out_f.req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_flit_cnt", flit_cnt, 0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (20) @(negedge clk);
    check("midrst_no_more_flits", req_rises - rises, 0);
    words[0] = 32'h0BAD_F00D;
    words[1] = 32'hFEED_FACE;
    send_pkt(6'd40, 2, 0, 0);

    rand_ack = 1'b1;
    for (int p = 0; p < 25; p++) begin
      l = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      send_pkt(6'($urandom_range(0, 63)), l, 3, 0);
    end
    rand_ack = 1'b0;

    @(posedge clk); #1;
    force_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("proto_err_not_yet", proto_err, 0);
    @(negedge clk);
    check("proto_err_set", proto_err, 1);
    @(posedge clk); #1;
    force_ack = 1'b0;
    repeat (6) @(negedge clk);
    check("proto_err_sticky", proto_err, 1);
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    @(negedge clk);
    check("proto_err_cleared", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
